// File: rtl/rsaasip_pipe_pkg.sv
// rsaasip_pipe_pkg: shared types and constants for the vector pipeline registers
package rsaasip_pipe_pkg;

    // Default geometry of the vector datapath
    localparam int DEF_ARQ   = 16;
    localparam int DEF_LANES = 4;
    localparam int DEF_RA_W  = 4;
    localparam int DEF_CNT_W = 16;

    // Writeback source select encoding
    localparam logic WB_SEL_ALU = 1'b0;
    localparam logic WB_SEL_MEM = 1'b1;

    // Packed lane vector at the default geometry, lane 0 in the LSBs
    typedef logic [DEF_LANES-1:0][DEF_ARQ-1:0] lane_vec_t;

endpackage

// File: rtl/memwb_lane.sv
// memwb_lane: one lane of the MEM/WB data registers plus its writeback mux
module memwb_lane
    import rsaasip_pipe_pkg::*;
#(
    parameter int ARQ = DEF_ARQ
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           hold,
    input  logic           clear,
    input  logic           sel,
    input  logic [ARQ-1:0] alu_in,
    input  logic [ARQ-1:0] mem_in,
    output logic [ARQ-1:0] alu_out,
    output logic [ARQ-1:0] mem_out,
    output logic [ARQ-1:0] wb_data
);

    // Lane data: clear on reset or bubble, hold on stall, otherwise capture
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            alu_out <= '0;
            mem_out <= '0;
        end else if (!hold) begin
            alu_out <= alu_in;
            mem_out <= mem_in;
        end
    end

    assign wb_data = (sel == WB_SEL_MEM) ? mem_out : alu_out;

endmodule

// File: rtl/memwb_pipe_vec.sv
// memwb_pipe_vec: MEM/WB pipeline register for the vector datapath with forwarding tap and retire counter
module memwb_pipe_vec
    import rsaasip_pipe_pkg::*;
#(
    parameter int ARQ   = DEF_ARQ,
    parameter int LANES = DEF_LANES,
    parameter int RA_W  = DEF_RA_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 valid_in,
    input  logic                 mem_rd_mux_in,
    input  logic                 wb_enable_in,
    input  logic [RA_W-1:0]      rd_addr_in,
    input  logic [LANES-1:0]     lane_mask_in,
    input  logic [LANES*ARQ-1:0] alu_result_in,
    input  logic [LANES*ARQ-1:0] mem_result_in,
    output logic                 valid_out,
    output logic                 mem_rd_mux_out,
    output logic                 wb_enable_out,
    output logic [RA_W-1:0]      rd_addr_out,
    output logic [LANES-1:0]     lane_we_out,
    output logic [LANES*ARQ-1:0] alu_result_out,
    output logic [LANES*ARQ-1:0] mem_result_out,
    output logic [LANES*ARQ-1:0] wb_data_out,
    output logic                 fwd_valid,
    output logic [RA_W-1:0]      fwd_addr,
    output logic [CNT_W-1:0]     retired_cnt
);

    logic             valid_q;
    logic             sel_q;
    logic             wb_q;
    logic [RA_W-1:0]  rd_q;
    logic [LANES-1:0] mask_q;
    logic [CNT_W-1:0] cnt_q;
    logic             retire;

    // Control registers; wb_enable is qualified by valid as it is captured
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid_q <= 1'b0;
            sel_q   <= WB_SEL_ALU;
            wb_q    <= 1'b0;
            rd_q    <= '0;
            mask_q  <= '0;
        end else if (!stall) begin
            valid_q <= valid_in;
            sel_q   <= mem_rd_mux_in;
            wb_q    <= wb_enable_in & valid_in;
            rd_q    <= rd_addr_in;
            mask_q  <= lane_mask_in;
        end
    end

    // The current occupant retires whenever it leaves the stage, even if the incoming one is flushed
    assign retire = valid_q & wb_q & ~stall & ~rst;

    // Saturating retired-writeback counter
    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else if (retire && (cnt_q != {CNT_W{1'b1}}))
            cnt_q <= cnt_q + 1'b1;
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        memwb_lane #(.ARQ(ARQ)) u_lane (
            .clk     (clk),
            .rst     (rst),
            .hold    (stall),
            .clear   (flush),
            .sel     (sel_q),
            .alu_in  (alu_result_in[l*ARQ +: ARQ]),
            .mem_in  (mem_result_in[l*ARQ +: ARQ]),
            .alu_out (alu_result_out[l*ARQ +: ARQ]),
            .mem_out (mem_result_out[l*ARQ +: ARQ]),
            .wb_data (wb_data_out[l*ARQ +: ARQ])
        );
    end

    assign valid_out      = valid_q;
    assign mem_rd_mux_out = sel_q;
    assign wb_enable_out  = wb_q & valid_q;
    assign rd_addr_out    = rd_q;
    assign lane_we_out    = mask_q & {LANES{wb_enable_out}};
    assign fwd_valid      = wb_enable_out;
    assign fwd_addr       = rd_q;
    assign retired_cnt    = cnt_q;

endmodule

// File: tb/tb_memwb_pipe_vec.sv
// tb_memwb_pipe_vec: directed self-checking bench for memwb_pipe_vec (LANES=4, ARQ=16, CNT_W=2)
module tb_memwb_pipe_vec;

    logic        clk = 1'b0;
    logic        rst, stall, flush, valid_in, mem_rd_mux_in, wb_enable_in;
    logic [3:0]  rd_addr_in, lane_mask_in;
    logic [63:0] alu_result_in, mem_result_in;
    logic        valid_out, mem_rd_mux_out, wb_enable_out, fwd_valid;
    logic [3:0]  rd_addr_out, lane_we_out, fwd_addr;
    logic [63:0] alu_result_out, mem_result_out, wb_data_out;
    logic [1:0]  retired_cnt;
    int          errors = 0;
    int          checks = 0;

    localparam logic [63:0] ALU_A = {16'd4, 16'd3, 16'd2, 16'd1110};
    localparam logic [63:0] MEM_A = {16'd40, 16'd30, 16'd20, 16'd1874};
    localparam logic [63:0] ALU_B = 64'h1111_2222_3333_4444;
    localparam logic [63:0] MEM_B = 64'h5555_6666_7777_8888;

    memwb_pipe_vec #(.ARQ(16), .LANES(4), .RA_W(4), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_in(valid_in),
        .mem_rd_mux_in(mem_rd_mux_in), .wb_enable_in(wb_enable_in), .rd_addr_in(rd_addr_in),
        .lane_mask_in(lane_mask_in), .alu_result_in(alu_result_in), .mem_result_in(mem_result_in),
        .valid_out(valid_out), .mem_rd_mux_out(mem_rd_mux_out), .wb_enable_out(wb_enable_out),
        .rd_addr_out(rd_addr_out), .lane_we_out(lane_we_out), .alu_result_out(alu_result_out),
        .mem_result_out(mem_result_out), .wb_data_out(wb_data_out), .fwd_valid(fwd_valid),
        .fwd_addr(fwd_addr), .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; stall = 0; flush = 0; valid_in = 0; mem_rd_mux_in = 0; wb_enable_in = 0;
        rd_addr_in = 0; lane_mask_in = 0; alu_result_in = 0; mem_result_in = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        step();
        rst = 0;
    endtask

    task automatic load_a(input logic sel);
        valid_in = 1; wb_enable_in = 1; mem_rd_mux_in = sel; rd_addr_in = 4'd5;
        lane_mask_in = 4'b1111; alu_result_in = ALU_A; mem_result_in = MEM_A;
    endtask

    task automatic test_reset();
        load_a(1'b1);
        stall = 0; flush = 0; rst = 1;
        repeat (3) step();
        checks++;
        if ({valid_out, mem_rd_mux_out, wb_enable_out, fwd_valid, rd_addr_out, lane_we_out, fwd_addr} !== 16'd0) begin
            errors++;
            $display("FAIL reset_ctrl got %h exp 0", {valid_out, mem_rd_mux_out, wb_enable_out, fwd_valid, rd_addr_out, lane_we_out, fwd_addr});
        end
        checks++;
        if ({alu_result_out, mem_result_out, wb_data_out} !== 192'd0) begin
            errors++;
            $display("FAIL reset_data got %h %h %h exp 0", alu_result_out, mem_result_out, wb_data_out);
        end
        checks++;
        if (retired_cnt !== 2'd0) begin
            errors++;
            $display("FAIL reset_cnt got %0d exp 0", retired_cnt);
        end
        rst = 0;
    endtask

    task automatic test_basic_load();
        do_reset();
        load_a(1'b1);
        step();
        checks++;
        if (wb_data_out !== MEM_A) begin
            errors++;
            $display("FAIL basic_wb_mem got %h exp %h", wb_data_out, MEM_A);
        end
        checks++;
        if (lane_we_out !== 4'b1111 || fwd_addr !== 4'd5 || fwd_valid !== 1'b1) begin
            errors++;
            $display("FAIL basic_ctrl got we=%b addr=%0d fv=%b exp we=1111 addr=5 fv=1", lane_we_out, fwd_addr, fwd_valid);
        end
        checks++;
        if (retired_cnt !== 2'd0) begin
            errors++;
            $display("FAIL basic_cnt0 got %0d exp 0", retired_cnt);
        end
        mem_rd_mux_in = 0;
        step();
        checks++;
        if (wb_data_out !== ALU_A || wb_data_out[15:0] !== 16'd1110) begin
            errors++;
            $display("FAIL basic_wb_alu got %h exp %h", wb_data_out, ALU_A);
        end
        checks++;
        if (retired_cnt !== 2'd1) begin
            errors++;
            $display("FAIL basic_cnt1 got %0d exp 1", retired_cnt);
        end
    endtask

    task automatic test_stall();
        do_reset();
        load_a(1'b0);
        rd_addr_in = 4'd3;
        step();
        stall = 1;
        rd_addr_in = 4'd9; alu_result_in = ALU_B; mem_result_in = MEM_B; mem_rd_mux_in = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (rd_addr_out !== 4'd3 || alu_result_out !== ALU_A || wb_data_out !== ALU_A || retired_cnt !== 2'd0) begin
                errors++;
                $display("FAIL stall_hold%0d got rd=%0d alu=%h wb=%h cnt=%0d exp rd=3 alu=%h cnt=0", i, rd_addr_out, alu_result_out, wb_data_out, retired_cnt, ALU_A);
            end
        end
        stall = 0;
        step();
        checks++;
        if (rd_addr_out !== 4'd9 || alu_result_out !== ALU_B || wb_data_out !== MEM_B) begin
            errors++;
            $display("FAIL stall_release got rd=%0d alu=%h wb=%h exp rd=9 alu=%h wb=%h", rd_addr_out, alu_result_out, wb_data_out, ALU_B, MEM_B);
        end
        checks++;
        if (retired_cnt !== 2'd1) begin
            errors++;
            $display("FAIL stall_cnt got %0d exp 1", retired_cnt);
        end
        valid_in = 0;
        step();
        checks++;
        if (retired_cnt !== 2'd2 || valid_out !== 1'b0 || alu_result_out !== ALU_B) begin
            errors++;
            $display("FAIL stall_drain got cnt=%0d v=%b alu=%h exp cnt=2 v=0 alu=%h", retired_cnt, valid_out, alu_result_out, ALU_B);
        end
    endtask

    task automatic test_flush();
        do_reset();
        load_a(1'b1);
        step();
        stall = 1; flush = 1;
        step();
        checks++;
        if (valid_out !== 1'b0 || wb_enable_out !== 1'b0 || wb_data_out !== 64'd0 || rd_addr_out !== 4'd0) begin
            errors++;
            $display("FAIL flush_stall got v=%b we=%b wb=%h rd=%0d exp all 0", valid_out, wb_enable_out, wb_data_out, rd_addr_out);
        end
        checks++;
        if (retired_cnt !== 2'd0) begin
            errors++;
            $display("FAIL flush_stall_cnt got %0d exp 0", retired_cnt);
        end
        stall = 0; flush = 0;
        step();
        flush = 1;
        step();
        checks++;
        if (valid_out !== 1'b0 || lane_we_out !== 4'd0 || mem_result_out !== 64'd0 || mem_rd_mux_out !== 1'b0) begin
            errors++;
            $display("FAIL flush_only got v=%b we=%b mem=%h sel=%b exp all 0", valid_out, lane_we_out, mem_result_out, mem_rd_mux_out);
        end
        checks++;
        if (retired_cnt !== 2'd1) begin
            errors++;
            $display("FAIL flush_retire got %0d exp 1", retired_cnt);
        end
        flush = 0;
    endtask

    task automatic test_mask();
        do_reset();
        load_a(1'b0);
        lane_mask_in = 4'b0101;
        step();
        checks++;
        if (lane_we_out !== 4'b0101 || fwd_valid !== 1'b1) begin
            errors++;
            $display("FAIL mask_0101 got we=%b fv=%b exp we=0101 fv=1", lane_we_out, fwd_valid);
        end
        checks++;
        if (alu_result_out !== ALU_A) begin
            errors++;
            $display("FAIL mask_data got %h exp %h", alu_result_out, ALU_A);
        end
        valid_in = 0; lane_mask_in = 4'b1111; alu_result_in = ALU_B;
        step();
        checks++;
        if (lane_we_out !== 4'b0000 || fwd_valid !== 1'b0 || wb_enable_out !== 1'b0 || alu_result_out !== ALU_B) begin
            errors++;
            $display("FAIL mask_invalid got we=%b fv=%b wbe=%b alu=%h exp 0 0 0 %h", lane_we_out, fwd_valid, wb_enable_out, alu_result_out, ALU_B);
        end
        valid_in = 1; wb_enable_in = 0;
        step();
        checks++;
        if (lane_we_out !== 4'b0000 || valid_out !== 1'b1 || wb_enable_out !== 1'b0) begin
            errors++;
            $display("FAIL mask_nowb got we=%b v=%b wbe=%b exp we=0000 v=1 wbe=0", lane_we_out, valid_out, wb_enable_out);
        end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_cnt;
        do_reset();
        load_a(1'b1);
        step();
        for (int i = 0; i < 5; i++) begin
            step();
            exp_cnt = (i < 2) ? 2'(i + 1) : 2'd3;
            checks++;
            if (retired_cnt !== exp_cnt) begin
                errors++;
                $display("FAIL sat_cnt%0d got %0d exp %0d", i, retired_cnt, exp_cnt);
            end
        end
        rst = 1;
        step();
        checks++;
        if (retired_cnt !== 2'd0 || valid_out !== 1'b0) begin
            errors++;
            $display("FAIL sat_reset got cnt=%0d v=%b exp 0 0", retired_cnt, valid_out);
        end
        rst = 0;
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        load_a(1'b1);
        step();
        step();
        stall = 1; flush = 1; rst = 1;
        step();
        checks++;
        if (retired_cnt !== 2'd0 || valid_out !== 1'b0 || wb_data_out !== 64'd0 || rd_addr_out !== 4'd0) begin
            errors++;
            $display("FAIL rst_mid_stall got cnt=%0d v=%b wb=%h rd=%0d exp all 0", retired_cnt, valid_out, wb_data_out, rd_addr_out);
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_basic_load();
        test_stall();
        test_flush();
        test_mask();
        test_saturation();
        test_reset_mid_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
